// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants and helpers used by fetch, decode and hazard logic.
package fetch_stage_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam int IMM_W  = 16;

  // sll $0,$0,0 is the all-zero word, so a bubble is simply zero.
  localparam logic [INST_W-1:0] DEF_NOP_INST = 32'h0000_0000;
  localparam logic [PC_W-1:0]   DEF_RESET_PC = 32'h0000_0000;

  // Which update the PC / IF/ID registers take on the next edge.
  typedef enum logic [1:0] {
    UPD_RESET,
    UPD_REDIRECT,
    UPD_HOLD,
    UPD_ADVANCE
  } pc_upd_e;

  // Word offset to byte offset: sign-extend to 30 bits, then append 2'b00.
  function automatic logic [PC_W-1:0] word_offset(input logic [IMM_W-1:0] imm);
    return {{(PC_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_branch_target.sv
// Branch target adder: ex_pc4 plus the sign-extended, word-scaled offset.
module branch_target
  import fetch_stage_pkg::*;
(
  input  logic [PC_W-1:0]  ex_pc4,
  input  logic [IMM_W-1:0] ex_imm16,
  output logic [PC_W-1:0]  target
);

  // Pure combinational add; wraps modulo 2^32.
  assign target = ex_pc4 + word_offset(ex_imm16);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, redirect bubble counter.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0]   RESET_PC = DEF_RESET_PC,
  parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   ex_pc4,
  input  logic [IMM_W-1:0]  ex_imm16,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] ifid_inst,
  output logic [PC_W-1:0]   ifid_pc4,
  output logic              ifid_valid,
  output logic              flush_idex,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [PC_W-1:0]   pc_reg,         pc_next;
  logic [INST_W-1:0] ifid_inst_reg,  ifid_inst_next;
  logic [PC_W-1:0]   ifid_pc4_reg,   ifid_pc4_next;
  logic              ifid_valid_reg, ifid_valid_next;
  logic [CNT_W-1:0]  bubble_cnt_reg, bubble_cnt_next;

  logic [PC_W-1:0]   pc4;
  logic [PC_W-1:0]   target;
  pc_upd_e           upd;

  branch_target u_branch_target (
    .ex_pc4   (ex_pc4),
    .ex_imm16 (ex_imm16),
    .target   (target)
  );

  assign pc4 = pc_reg + 32'd4;

  // Select this edge's update: reset > redirect > stall > advance.
  always_comb begin
    upd = UPD_ADVANCE;
    if (reset) begin
      upd = UPD_RESET;
    end else if (br_taken) begin
      // A stalled ID instruction is younger than the branch, so it dies too.
      upd = UPD_REDIRECT;
    end else if (stall) begin
      upd = UPD_HOLD;
    end
  end

  // Next-state values for PC, IF/ID and the bubble counter.
  always_comb begin
    pc_next         = pc_reg;
    ifid_inst_next  = ifid_inst_reg;
    ifid_pc4_next   = ifid_pc4_reg;
    ifid_valid_next = ifid_valid_reg;
    bubble_cnt_next = bubble_cnt_reg;
    unique case (upd)
      UPD_RESET: begin
        pc_next         = RESET_PC;
        ifid_inst_next  = NOP_INST;
        ifid_pc4_next   = '0;
        ifid_valid_next = 1'b0;
        bubble_cnt_next = '0;
      end
      UPD_REDIRECT: begin
        pc_next         = target;
        ifid_inst_next  = NOP_INST;
        ifid_pc4_next   = '0;
        ifid_valid_next = 1'b0;
        if (!(&bubble_cnt_reg)) begin
          bubble_cnt_next = bubble_cnt_reg + CNT_W'(1);
        end
      end
      UPD_HOLD: begin
        // Everything holds; imem_data is ignored this cycle.
      end
      UPD_ADVANCE: begin
        pc_next         = pc4;
        ifid_inst_next  = imem_data;
        ifid_pc4_next   = pc4;
        ifid_valid_next = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State registers; synchronous reset also handled here for clarity.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg         <= RESET_PC;
      ifid_inst_reg  <= NOP_INST;
      ifid_pc4_reg   <= '0;
      ifid_valid_reg <= 1'b0;
      bubble_cnt_reg <= '0;
    end else begin
      pc_reg         <= pc_next;
      ifid_inst_reg  <= ifid_inst_next;
      ifid_pc4_reg   <= ifid_pc4_next;
      ifid_valid_reg <= ifid_valid_next;
      bubble_cnt_reg <= bubble_cnt_next;
    end
  end

  assign imem_addr  = pc_reg;
  assign ifid_inst  = ifid_inst_reg;
  assign ifid_pc4   = ifid_pc4_reg;
  assign ifid_valid = ifid_valid_reg;
  assign bubble_cnt = bubble_cnt_reg;
  // ID/EX must kill on the same edge the branch redirects.
  assign flush_idex = br_taken;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a scoreboard of expected IF state.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken;
  logic [31:0] ex_pc4;
  logic [15:0] ex_imm16;

  logic [31:0] imem_addr, imem_data, ifid_inst, ifid_pc4;
  logic        ifid_valid, flush_idex;
  logic [15:0] bubble_cnt;

  logic [31:0] sat_imem_addr, sat_imem_data, sat_ifid_inst, sat_ifid_pc4;
  logic        sat_ifid_valid, sat_flush_idex;
  logic [1:0]  sat_bubble_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sb[$];

  // Reference state of the fetch stage, advanced once per driven cycle.
  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_valid;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;

  // Distinct, address-dependent instruction words.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {a[15:0], a[31:16]} ^ 32'h0000_1111;
  endfunction

  assign imem_data     = imem_word(imem_addr);
  assign sat_imem_data = imem_word(sat_imem_addr);

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .ex_pc4(ex_pc4), .ex_imm16(ex_imm16), .imem_addr(imem_addr),
    .imem_data(imem_data), .ifid_inst(ifid_inst), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .flush_idex(flush_idex), .bubble_cnt(bubble_cnt)
  );

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .ex_pc4(ex_pc4), .ex_imm16(ex_imm16), .imem_addr(sat_imem_addr),
    .imem_data(sat_imem_data), .ifid_inst(sat_ifid_inst), .ifid_pc4(sat_ifid_pc4),
    .ifid_valid(sat_ifid_valid), .flush_idex(sat_flush_idex), .bubble_cnt(sat_bubble_cnt)
  );

  // Drive one cycle, push the expected post-edge state, then pop and compare.
  task automatic step(input string tag, input logic rst, input logic st, input logic br,
                      input logic [31:0] p4, input logic [15:0] imm);
    exp_t e, g;
    logic [31:0] tgt;
    reset = rst; stall = st; br_taken = br; ex_pc4 = p4; ex_imm16 = imm;
    #1;
    checks++;
    if (flush_idex !== br) begin
      errors++;
      $display("FAIL %s flush_idex: got %b expected %b", tag, flush_idex, br);
    end
    tgt = p4 + {{14{imm[15]}}, imm, 2'b00};
    if (rst) begin
      m_pc = RST_PC; m_inst = NOP; m_pc4 = 0; m_valid = 0; m_cnt = 0; m_cnt2 = 0;
    end else if (br) begin
      m_pc = tgt; m_inst = NOP; m_pc4 = 0; m_valid = 0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 1;
    end else if (!st) begin
      m_inst = imem_word(m_pc); m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
    end
    e.addr = m_pc; e.inst = m_inst; e.pc4 = m_pc4; e.valid = m_valid;
    e.cnt = m_cnt; e.cnt2 = m_cnt2;
    sb.push_back(e);
    @(posedge clk); #1;
    g = sb.pop_front();
    checks += 6;
    if (imem_addr !== g.addr) begin
      errors++; $display("FAIL %s imem_addr: got %h expected %h", tag, imem_addr, g.addr);
    end
    if (ifid_inst !== g.inst) begin
      errors++; $display("FAIL %s ifid_inst: got %h expected %h", tag, ifid_inst, g.inst);
    end
    if (ifid_pc4 !== g.pc4) begin
      errors++; $display("FAIL %s ifid_pc4: got %h expected %h", tag, ifid_pc4, g.pc4);
    end
    if (ifid_valid !== g.valid) begin
      errors++; $display("FAIL %s ifid_valid: got %b expected %b", tag, ifid_valid, g.valid);
    end
    if (bubble_cnt !== g.cnt) begin
      errors++; $display("FAIL %s bubble_cnt: got %0d expected %0d", tag, bubble_cnt, g.cnt);
    end
    if (sat_bubble_cnt !== g.cnt2) begin
      errors++; $display("FAIL %s sat_bubble_cnt: got %0d expected %0d", tag, sat_bubble_cnt, g.cnt2);
    end
    $display("txn %-10s rst=%b stall=%b br=%b addr=%h inst=%h pc4=%h v=%b cnt=%0d sat=%0d",
             tag, rst, st, br, imem_addr, ifid_inst, ifid_pc4, ifid_valid, bubble_cnt, sat_bubble_cnt);
  endtask

  task automatic test_reset();
    step("reset", 1, 0, 0, 0, 0);
    step("reset", 1, 0, 0, 0, 0);
    checks += 3;
    if (imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_pc: got %h expected %h", imem_addr, 32'h0);
    end
    if (ifid_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", ifid_valid);
    end
    if (bubble_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d expected 0", bubble_cnt);
    end
  endtask

  task automatic test_fetch();
    step("fetch", 0, 0, 0, 0, 0);
    checks += 2;
    if (ifid_inst !== imem_word(32'h0) || ifid_pc4 !== 32'd4) begin
      errors++; $display("FAIL fetch_A: got %h/%h expected %h/4", ifid_inst, ifid_pc4, imem_word(32'h0));
    end
    if (ifid_valid !== 1'b1) begin
      errors++; $display("FAIL fetch_valid: got %b expected 1", ifid_valid);
    end
    step("fetch", 0, 0, 0, 0, 0);
    checks++;
    if (ifid_inst !== imem_word(32'h4) || imem_addr !== 32'd8) begin
      errors++; $display("FAIL fetch_B: got %h@%h expected %h@8", ifid_inst, imem_addr, imem_word(32'h4));
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step("stall", 0, 1, 0, 0, 0);
      checks++;
      if (ifid_inst !== imem_word(32'h4) || imem_addr !== 32'd8) begin
        errors++; $display("FAIL stall_hold: got %h@%h expected %h@8", ifid_inst, imem_addr, imem_word(32'h4));
      end
    end
    step("resume", 0, 0, 0, 0, 0);
    checks++;
    if (ifid_inst !== imem_word(32'h8) || ifid_pc4 !== 32'd12) begin
      errors++; $display("FAIL resume_C: got %h/%h expected %h/c", ifid_inst, ifid_pc4, imem_word(32'h8));
    end
    step("resume", 0, 0, 0, 0, 0);
    checks++;
    if (ifid_inst !== imem_word(32'hC)) begin
      errors++; $display("FAIL resume_D: got %h expected %h", ifid_inst, imem_word(32'hC));
    end
  endtask

  task automatic test_branch();
    step("branch", 0, 0, 1, 32'h20, 16'hFFFE);
    checks++;
    if (imem_addr !== 32'h18 || ifid_inst !== NOP || ifid_valid !== 1'b0 || bubble_cnt !== 16'd1) begin
      errors++; $display("FAIL branch_redirect: got addr=%h inst=%h v=%b cnt=%0d expected 18/0/0/1",
                         imem_addr, ifid_inst, ifid_valid, bubble_cnt);
    end
    step("after_br", 0, 0, 0, 0, 0);
    checks++;
    if (ifid_inst !== imem_word(32'h18) || ifid_pc4 !== 32'h1C || ifid_valid !== 1'b1) begin
      errors++; $display("FAIL branch_target_fetch: got %h/%h expected %h/1c", ifid_inst, ifid_pc4, imem_word(32'h18));
    end
  endtask

  task automatic test_branch_stall();
    step("br+stall", 0, 1, 1, 32'h40, 16'h0003);
    checks++;
    if (imem_addr !== 32'h4C || ifid_valid !== 1'b0 || bubble_cnt !== 16'd2) begin
      errors++; $display("FAIL br_over_stall: got addr=%h v=%b cnt=%0d expected 4c/0/2", imem_addr, ifid_valid, bubble_cnt);
    end
    step("after_br", 0, 0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    step("to_top", 0, 0, 1, 32'h0, 16'hFFFF);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_preset: got %h expected fffffffc", imem_addr);
    end
    step("wrap", 0, 0, 0, 0, 0);
    checks++;
    if (imem_addr !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b1) begin
      errors++; $display("FAIL wrap: got addr=%h pc4=%h v=%b expected 0/0/1", imem_addr, ifid_pc4, ifid_valid);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 3; i++) step("redirect", 0, 0, 1, 32'h100, 16'h0000);
    checks++;
    if (sat_bubble_cnt !== 2'd3 || bubble_cnt !== 16'd6) begin
      errors++; $display("FAIL saturate: got sat=%0d cnt=%0d expected 3/6", sat_bubble_cnt, bubble_cnt);
    end
  endtask

  task automatic test_reset_mid();
    step("stall", 0, 1, 0, 0, 0);
    step("rst_mid", 1, 1, 1, 32'h80, 16'h0005);
    checks++;
    if (imem_addr !== RST_PC || ifid_valid !== 1'b0 || bubble_cnt !== 16'd0 || sat_bubble_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_mid: got addr=%h v=%b cnt=%0d expected 0/0/0", imem_addr, ifid_valid, bubble_cnt);
    end
    step("restart", 0, 0, 0, 0, 0);
    checks++;
    if (ifid_inst !== imem_word(RST_PC) || imem_addr !== 32'h4) begin
      errors++; $display("FAIL restart: got %h@%h expected %h@4", ifid_inst, imem_addr, imem_word(RST_PC));
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; ex_pc4 = '0; ex_imm16 = '0;
    @(posedge clk); #1;
    test_reset();
    test_fetch();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipelined CPU: owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register that feeds decode and control. It also applies load-use stalls from the hazard unit and taken-branch redirects resolved in EX. On a redirect it squashes wrong-path instructions by inserting bubbles and signalling a flush to ID/EX.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, encoding placed in IF/ID on a bubble (sll $0,$0,0).
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  load-use stall from hazard unit; hold PC and IF/ID.
- br_taken  in  1  EX-stage branch resolved taken (nPC_sel).
- ex_pc4  in  32  PC+4 of the branch instruction in EX.
- ex_imm16  in  16  branch offset of the instruction in EX, in words.
- imem_addr  out  32  instruction-memory address; equals the PC register.
- imem_data  in  32  instruction word, combinational read of imem_addr.
- ifid_inst  out  32  IF/ID instruction register.
- ifid_pc4  out  32  IF/ID PC+4 register.
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- flush_idex  out  1  combinational; equals br_taken; ID/EX loads a bubble.
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted by redirects.

## Operation
- pc4 = pc + 4, modulo 2^32.
- target = ex_pc4 + {sext(ex_imm16), 2'b00}, modulo 2^32, where sext sign-extends to 30 bits.
- Per-edge priority: reset > br_taken > stall > normal.
- Reset: pc <= RESET_PC; ifid_inst <= NOP_INST; ifid_pc4 <= 0; ifid_valid <= 0; bubble_cnt <= 0.
- br_taken:
  - pc <= target.
  - ifid_inst <= NOP_INST; ifid_valid <= 0; ifid_pc4 <= 0.
  - bubble_cnt increments by 1, saturating at all-ones.
  - Overrides a simultaneous stall: the stalled ID instruction is wrong-path.
- stall (without br_taken): pc, ifid_inst, ifid_pc4, ifid_valid hold; imem_data is ignored.
- Normal: pc <= pc4; ifid_inst <= imem_data; ifid_pc4 <= pc4; ifid_valid <= 1.
- No branch prediction. A taken branch squashes the two younger instructions, in IF and ID.
- Not-taken branches cost nothing. bubble_cnt does not count stall cycles.
- PC is not alignment-checked. The low two bits stay 00 as long as RESET_PC is word aligned.

## Timing
- Fetch latency 1 cycle: an instruction addressed in cycle N appears on ifid_inst in cycle N+1.
- Redirect: br_taken high in cycle N gives imem_addr = target in N+1. That instruction reaches ifid_inst in N+2.
- flush_idex has zero latency (same cycle as br_taken), so ID/EX kills on the same edge.
- Reset mid-operation discards any pending stall or branch. The first valid fetch is RESET_PC in the cycle after reset deasserts, and it appears in IF/ID one cycle later.
- stall held for k cycles freezes outputs for k cycles, then fetch resumes with no lost or duplicated instruction.
- PC wrap: pc = 32'hFFFF_FFFC gives next pc = 0 and ifid_pc4 = 0.

## Structure
- The shared CPU package holds INST_W = 32, NOP_INST, the default RESET_PC, and the PC-width constant. Decode and hazard logic use the same values.
- One sub-module, branch_target: purely combinational sign-extend, shift, and add producing target from ex_pc4 and ex_imm16.
- The PC register, IF/ID register, and bubble counter stay in fetch_stage.

## Test plan
- Reset, then 4 free-running cycles with imem = {A,B,C,D} at 0,4,8,12 -> ifid_inst = A,B,C in successive cycles; ifid_pc4 = 4,8,12; ifid_valid = 1 from the second cycle.
- stall high 3 cycles while ifid_inst = B, imem_addr = 8 -> outputs frozen for 3 cycles, then C, D with no skip or repeat.
- br_taken with ex_pc4 = 0x20, ex_imm16 = 0xFFFE -> imem_addr = 0x18 next cycle; ifid_valid = 0 and ifid_inst = NOP_INST for one cycle; flush_idex high that cycle; bubble_cnt +1.
- br_taken and stall in the same cycle, ex_pc4 = 0x40, ex_imm16 = 3 -> redirect to 0x4C wins; bubble inserted; PC not held.
- PC preset near 0xFFFF_FFFC, then normal fetch -> next imem_addr = 0; ifid_pc4 = 0. Also, with CNT_W forced to 2, five redirects -> bubble_cnt saturates at 3.
- Reset asserted during a stall and a branch -> all outputs take reset values on that edge; fetch restarts at RESET_PC.
